pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised successor to the fixed-field inter-stage pipeline registers (e.g. MEM/WB). It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake. A 2-entry skid buffer registers the backpressure path, and the block adds a stall input, a flush input and a saturating stall-cycle counter. It is dropped between any two stages where the downstream stage can stall, such as memory wait or a bus handshake.

Parameters:
DATA_W, 74, payload width in bits (WE 5 + ALU 32 + rd 5 + DM 32 for the MEM/WB use).
RST_VAL, 0, reset value of out_data and the skid entry (DATA_W bits, zero-extended).
SKID_EN, 1, 1 = 2-entry skid with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 16, width of stall_cnt.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream payload valid.
in_ready  output  1  block can accept the payload this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data holds a valid payload.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  payload to downstream, driven straight from a register.
hold  input  1  stall; suppresses output transfer (same role as the waiting input of the existing stage registers).
flush  input  1  discard all held and incoming payloads.
stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Handshake definitions:
  - acc_in = in_valid & in_ready.
  - acc_out = out_valid & out_ready & ~hold.
  - hold is treated exactly as out_ready=0.
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=RST_VAL, skid entry=RST_VAL.
  - in_ready=1, stall_cnt=0, state EMPTY.
  - Reset mid-transfer drops all payloads. The first acc_in is possible on the first rising edge after rst deasserts.
- States (SKID_EN=1):
  - EMPTY: out_valid=0. acc_in -> FULL, with out_data<=in_data.
  - FULL: out_valid=1.
    - acc_in & acc_out: out_data<=in_data, stay in FULL.
    - acc_out only: -> EMPTY.
    - acc_in only: skid<=in_data, -> SKID.
    - Neither: hold everything.
  - SKID: out_valid=1, in_ready=0.
    - acc_out: out_data<=skid, -> FULL.
    - Otherwise stay in SKID.
- in_ready is a register: next in_ready = (next state != SKID). No combinational path from out_ready or hold to in_ready.
- SKID_EN=0:
  - Only EMPTY and FULL exist.
  - in_ready = ~out_valid | acc_out (combinational).
  - Behaves as a classic stallable stage register.
- Ordering: payloads leave in acceptance order. No duplication and no loss except on flush or reset.
- Latency:
  - Minimum 1 cycle: accepted at edge N, visible on out_data after edge N.
  - Full throughput of 1 payload/cycle when out_ready=1 and hold=0.
- Flush (synchronous, highest priority):
  - Next state is EMPTY, out_valid<=0, in_ready<=1.
  - Any same-cycle acc_in is discarded.
  - out_data and skid retain their values; they are don't-care while invalid.
  - flush together with hold: flush wins.
- Empty output: out_data retains the last payload while out_valid=0. Consumers must qualify with out_valid.
- stall_cnt:
  - Increments on every cycle with out_valid & (~out_ready | hold).
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by reset.
- No X propagation: every register has a reset value.

Test Plan:
- Streaming: out_ready=1, hold=0, in_valid=1, in_data=1,2,3…10 for 10 cycles -> out_data=1…10 on consecutive cycles starting 1 cycle later; in_ready stays 1; stall_cnt=0.
- Skid fill: FULL holding 0xA, out_ready drops while 0xB is accepted -> next cycle in_ready=0, out_data=0xA. Raise out_ready -> out_data=0xA, then 0xB; in_ready returns to 1 the cycle after 0xA leaves.
- Hold: 0x5 valid, out_ready=1, hold=1 for 4 cycles -> out_data stays 0x5, out_valid=1, stall_cnt=4. Drop hold -> 0x5 consumed once.
- Flush in SKID state with in_valid=1, in_data=0x7 -> next cycle out_valid=0, in_ready=1; 0x7 is never output; stall_cnt unchanged.
- Saturation with CNT_W=3: 12 stalled cycles -> stall_cnt=7 and stays 7.
- Async reset: assert rst=0 mid-stream, between clock edges -> out_valid=0 and out_data=RST_VAL immediately. Repeat the streaming test with SKID_EN=0 and confirm in_ready follows out_ready combinationally.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with optional 2-entry skid, hold/flush controls and stall counter.
// Latency: 1 cycle from acceptance to out_data; 1 payload/cycle sustained when unstalled.
// Backpressure: SKID_EN=1 gives a registered in_ready (skid absorbs one beat); SKID_EN=0 gives a combinational in_ready.
module pipe_skid_reg #(
  parameter int                DATA_W  = 74,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit                SKID_EN = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] skid_q, skid_d, out_data_d;
  logic              in_ready_q, in_ready_d;
  logic              acc_in, acc_out;

  assign out_valid = (state_q != EMPTY);
  // hold behaves exactly like a deasserted out_ready
  assign acc_out   = out_valid & out_ready & ~hold;
  assign in_ready  = SKID_EN ? in_ready_q : (~out_valid | acc_out);
  assign acc_in    = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data;
    skid_d     = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_in) begin
            state_d    = FULL;
            out_data_d = in_data;
          end
        end
        FULL: begin
          if (acc_in && acc_out) begin
            out_data_d = in_data;
          end else if (acc_out) begin
            state_d = EMPTY;
          end else if (acc_in && SKID_EN) begin
            state_d = SKID;
            skid_d  = in_data;
          end
        end
        SKID: begin
          if (acc_out) begin
            state_d    = FULL;
            out_data_d = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      out_data   <= RST_VAL;
      skid_q     <= RST_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_data   <= out_data_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Saturates instead of wrapping; flush deliberately leaves it alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && (!out_ready || hold) && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table, scoreboard, saturation, async reset and SKID_EN=0 instance.
module tb_pipe_skid_reg;

  localparam int             DW = 74;
  localparam logic [DW-1:0]  RV = 74'hC3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, hold, flush;
  logic [DW-1:0] in_data, out_data;
  logic [15:0]   stall_cnt;

  logic          c3_in_ready, c3_out_valid;
  logic [7:0]    c3_out_data;
  logic [2:0]    c3_stall_cnt;

  logic          ns_in_valid, ns_in_ready, ns_out_valid, ns_out_ready, ns_hold, ns_flush;
  logic [7:0]    ns_in_data, ns_out_data;
  logic [15:0]   ns_stall_cnt;

  pipe_skid_reg #(.DATA_W(DW), .RST_VAL(RV), .SKID_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hold(hold), .flush(flush), .stall_cnt(stall_cnt));

  pipe_skid_reg #(.DATA_W(8), .RST_VAL(8'h00), .SKID_EN(1'b1), .CNT_W(3)) dut_c3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c3_in_ready), .in_data(in_data[7:0]),
    .out_valid(c3_out_valid), .out_ready(out_ready), .out_data(c3_out_data),
    .hold(hold), .flush(flush), .stall_cnt(c3_stall_cnt));

  pipe_skid_reg #(.DATA_W(8), .RST_VAL(8'h00), .SKID_EN(1'b0), .CNT_W(16)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data),
    .hold(ns_hold), .flush(ns_flush), .stall_cnt(ns_stall_cnt));

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       h;
    logic       fl;
    logic       e_ov;
    logic       e_ir;
    logic [7:0] e_od;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t          vt[18];
  logic [DW-1:0] sb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_pop = 0;

  function automatic vec_t mk(logic iv, logic [7:0] d, logic ordy, logic h, logic fl,
                              logic e_ov, logic e_ir, logic [7:0] e_od, logic [15:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.h = h; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic h, input logic fl);
    in_valid  = iv;
    in_data   = '0;
    in_data[7:0] = d;
    out_ready = ordy;
    hold      = h;
    flush     = fl;
  endtask

  // Scoreboard step, called once per cycle while the main DUT's inputs are stable
  task automatic monitor();
    logic [DW-1:0] e;
    if (out_valid && out_ready && !hold) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_pop: got %0h, expected no output", out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 80'(out_data), 80'(e));
        n_pop++;
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    ns_in_valid = 0; ns_in_data = 0; ns_out_ready = 0; ns_hold = 0; ns_flush = 0;

    vt[0]  = mk(1, 8'h0A, 1, 0, 0,  0, 1, 8'hC3, 16'd0);
    vt[1]  = mk(1, 8'h0B, 0, 0, 0,  1, 1, 8'h0A, 16'd0);
    vt[2]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 8'h0A, 16'd1);
    vt[3]  = mk(0, 8'h00, 1, 0, 0,  1, 0, 8'h0A, 16'd2);
    vt[4]  = mk(0, 8'h00, 1, 0, 0,  1, 1, 8'h0B, 16'd2);
    vt[5]  = mk(1, 8'h05, 1, 1, 0,  0, 1, 8'h0B, 16'd2);
    vt[6]  = mk(0, 8'h00, 1, 1, 0,  1, 1, 8'h05, 16'd2);
    vt[7]  = mk(0, 8'h00, 1, 1, 0,  1, 1, 8'h05, 16'd3);
    vt[8]  = mk(0, 8'h00, 1, 1, 0,  1, 1, 8'h05, 16'd4);
    vt[9]  = mk(0, 8'h00, 1, 1, 0,  1, 1, 8'h05, 16'd5);
    vt[10] = mk(0, 8'h00, 1, 0, 0,  1, 1, 8'h05, 16'd6);
    vt[11] = mk(1, 8'h09, 0, 0, 0,  0, 1, 8'h05, 16'd6);
    vt[12] = mk(1, 8'h0C, 0, 0, 0,  1, 1, 8'h09, 16'd6);
    vt[13] = mk(1, 8'h07, 1, 0, 1,  1, 0, 8'h09, 16'd7);
    vt[14] = mk(0, 8'h00, 1, 0, 0,  0, 1, 8'h09, 16'd7);
    vt[15] = mk(1, 8'h0D, 0, 0, 0,  0, 1, 8'h09, 16'd7);
    vt[16] = mk(0, 8'h00, 1, 1, 1,  1, 1, 8'h0D, 16'd7);
    vt[17] = mk(0, 8'h00, 1, 0, 0,  0, 1, 8'h0D, 16'd8);

    #12;
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_in_ready",  80'(in_ready),  80'(1));
    chk("rst_out_data",  80'(out_data),  80'(RV));
    chk("rst_stall_cnt", 80'(stall_cnt), 80'(0));
    chk("rst_ns_ready",  80'(ns_in_ready), 80'(1));
    @(negedge clk);
    rst = 1'b1;
    adv();

    // Skid fill, hold, flush in SKID and flush-with-hold
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].h, vt[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 80'(out_valid), 80'(vt[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i),  80'(in_ready),  80'(vt[i].e_ir));
      chk($sformatf("vec%0d_out_data", i),  80'(out_data),  80'(vt[i].e_od));
      chk($sformatf("vec%0d_stall_cnt", i), 80'(stall_cnt), 80'(vt[i].e_cnt));
      monitor();
      adv();
    end

    // Full-throughput streaming
    p0 = n_pop;
    for (int i = 1; i <= 12; i++) begin
      drive(i <= 10, 8'(i), 1, 0, 0);
      @(negedge clk);
      chk("stream_in_ready", 80'(in_ready), 80'(1));
      chk("stream_out_valid", 80'(out_valid), 80'(i > 1 && i <= 11));
      monitor();
      adv();
    end
    chk("stream_pops", 80'(n_pop - p0), 80'(10));
    chk("stream_stall_cnt", 80'(stall_cnt), 80'(8));

    // Asynchronous reset between edges while streaming
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h20 + i), 1, 0, 0);
      @(negedge clk);
      monitor();
      adv();
    end
    chk("pre_rst_out_valid", 80'(out_valid), 80'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 80'(out_valid), 80'(0));
    chk("arst_out_data",  80'(out_data),  80'(RV));
    chk("arst_in_ready",  80'(in_ready),  80'(1));
    chk("arst_stall_cnt", 80'(stall_cnt), 80'(0));
    sb.delete();
    drive(0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    adv();

    // Counter saturation on the CNT_W=3 instance
    drive(1, 8'h33, 0, 0, 0);
    @(negedge clk);
    monitor();
    adv();
    for (int k = 0; k <= 12; k++) begin
      drive(0, 8'h00, 0, 0, 0);
      @(negedge clk);
      chk("sat_cnt16", 80'(stall_cnt), 80'(k));
      chk("sat_cnt3", 80'(c3_stall_cnt), 80'((k > 7) ? 7 : k));
      monitor();
      adv();
    end
    drive(0, 8'h00, 1, 0, 0);
    @(negedge clk);
    chk("sat_cnt16_end", 80'(stall_cnt), 80'(13));
    chk("sat_cnt3_end", 80'(c3_stall_cnt), 80'(7));
    monitor();
    adv();
    drive(0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("sat_drained", 80'(out_valid), 80'(0));
    chk("sat_sb_empty", 80'(sb.size()), 80'(0));
    adv();

    // SKID_EN=0: streaming, then combinational in_ready
    for (int k = 0; k < 10; k++) begin
      ns_in_valid = 1; ns_in_data = 8'(k + 1); ns_out_ready = 1; ns_hold = 0;
      @(negedge clk);
      chk("ns_in_ready", 80'(ns_in_ready), 80'(1));
      chk("ns_out_valid", 80'(ns_out_valid), 80'(k > 0));
      if (k > 0) chk("ns_out_data", 80'(ns_out_data), 80'(k));
      adv();
    end
    ns_in_valid = 0; ns_out_ready = 0;
    #1;
    chk("ns_comb_rdy0", 80'(ns_in_ready), 80'(0));
    ns_out_ready = 1;
    #1;
    chk("ns_comb_rdy1", 80'(ns_in_ready), 80'(1));
    ns_hold = 1;
    #1;
    chk("ns_comb_hold", 80'(ns_in_ready), 80'(0));
    ns_hold = 0;
    @(negedge clk);
    chk("ns_last_valid", 80'(ns_out_valid), 80'(1));
    chk("ns_last_data", 80'(ns_out_data), 80'(10));
    adv();
    ns_out_ready = 0;
    #1;
    chk("ns_empty_valid", 80'(ns_out_valid), 80'(0));
    chk("ns_empty_ready", 80'(ns_in_ready), 80'(1));
    chk("ns_stall_cnt", 80'(ns_stall_cnt), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
